// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus an independent debounce counter per push-button channel.
// Each channel yields a registered clean level and a one-cycle strobe on every accepted press.
module button_debouncer #(
    parameter int N_BUTTONS       = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NB_COUNTER      = 20
) (
    input  logic                 I_clk,
    input  logic                 I_reset_n,
    input  logic [N_BUTTONS-1:0] I_button_raw,
    output logic [N_BUTTONS-1:0] O_level,
    output logic [N_BUTTONS-1:0] O_pulse
);

    localparam logic [NB_COUNTER-1:0] LAST_COUNT = NB_COUNTER'(DEBOUNCE_CYCLES - 1);

    logic [N_BUTTONS-1:0]  sync1;
    logic [N_BUTTONS-1:0]  sync2;
    logic [NB_COUNTER-1:0] count      [N_BUTTONS];
    logic [NB_COUNTER-1:0] count_next [N_BUTTONS];
    logic [N_BUTTONS-1:0]  level_next;
    logic [N_BUTTONS-1:0]  pulse_next;

    // Only sync2 feeds the debounce logic; the raw lines are touched by sync1 alone.
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= I_button_raw;
            sync2 <= sync1;
        end
    end

    // A disagreement must persist for DEBOUNCE_CYCLES consecutive edges before it is accepted;
    // any agreement clears the count, so the counter saturates at LAST_COUNT and never wraps.
    always_comb begin
        level_next = O_level;
        pulse_next = '0;
        for (int i = 0; i < N_BUTTONS; i++) begin
            count_next[i] = '0;
            if (sync2[i] != O_level[i]) begin
                if (count[i] == LAST_COUNT) begin
                    level_next[i] = sync2[i];
                    pulse_next[i] = sync2[i];
                end else begin
                    count_next[i] = count[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                count[i] <= '0;
            end
            O_level <= '0;
            O_pulse <= '0;
        end else begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                count[i] <= count_next[i];
            end
            O_level <= level_next;
            O_pulse <= pulse_next;
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios with literal expectations plus random
// bouncing stimulus compared every cycle against a sliding-window behavioural model.
module tb_button_debouncer;

    localparam int NB = 3;
    localparam int D  = 4;

    logic          I_clk = 1'b0;
    logic          I_reset_n;
    logic [NB-1:0] I_button_raw;
    logic [NB-1:0] O_level;
    logic [NB-1:0] O_pulse;

    int n_checks = 0;
    int n_pass   = 0;
    int pcnt [NB];

    button_debouncer #(
        .N_BUTTONS      (NB),
        .DEBOUNCE_CYCLES(D),
        .NB_COUNTER     (3)
    ) dut (
        .I_clk       (I_clk),
        .I_reset_n   (I_reset_n),
        .I_button_raw(I_button_raw),
        .O_level     (O_level),
        .O_pulse     (O_pulse)
    );

    // clock / reset
    always #5 I_clk = ~I_clk;

    // behavioural model: raw is seen two edges late; a level flips once the last D
    // observed samples all disagree with it, and a press strobes in that same cycle
    logic [NB-1:0] pipe_q [$];
    logic [NB-1:0] win_q  [$];
    logic [NB-1:0] lvl_m;
    logic [NB-1:0] pls_m;

    task automatic model_reset();
        lvl_m = '0;
        pls_m = '0;
        pipe_q.delete();
        pipe_q.push_back('0);
        pipe_q.push_back('0);
        win_q.delete();
        repeat (D) win_q.push_back('0);
    endtask

    always @(posedge I_clk or negedge I_reset_n) begin
        logic [NB-1:0] din;
        bit all_diff;
        if (!I_reset_n) begin
            model_reset();
        end else begin
            din = pipe_q.pop_front();
            pipe_q.push_back(I_button_raw);
            void'(win_q.pop_front());
            win_q.push_back(din);
            pls_m = '0;
            for (int i = 0; i < NB; i++) begin
                all_diff = 1'b1;
                foreach (win_q[k]) if (win_q[k][i] == lvl_m[i]) all_diff = 1'b0;
                if (all_diff) begin
                    lvl_m[i] = ~lvl_m[i];
                    pls_m[i] = lvl_m[i];
                end
            end
        end
    end

    // scoreboard helpers
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge I_clk) begin
        check("cyc_level", int'(O_level), int'(lvl_m));
        check("cyc_pulse", int'(O_pulse), int'(pls_m));
    end

    // driver tasks
    task automatic step();
        @(posedge I_clk);
        #1;
        for (int i = 0; i < NB; i++) if (O_pulse[i]) pcnt[i]++;
    endtask

    task automatic clear_pcnt();
        for (int i = 0; i < NB; i++) pcnt[i] = 0;
    endtask

    task automatic drive(input logic [NB-1:0] v);
        @(negedge I_clk);
        I_button_raw = v;
    endtask

    initial begin
        int hold;
        model_reset();
        clear_pcnt();
        I_reset_n    = 1'b0;
        I_button_raw = 3'b111;
        #1;
        check("reset_level", int'(O_level), 0);
        check("reset_pulse", int'(O_pulse), 0);
        repeat (3) @(negedge I_clk);
        I_button_raw = 3'b000;
        @(negedge I_clk);
        I_reset_n = 1'b1;
        repeat (3) step();

        // clean press and long hold
        drive(3'b001);
        clear_pcnt();
        repeat (5) step();
        check("press_level_e5", int'(O_level[0]), 0);
        step();
        check("press_level_e6", int'(O_level[0]), 1);
        check("press_pulse_e6", int'(O_pulse[0]), 1);
        check("model_pulse_e6", int'(pls_m), 1);
        step();
        check("press_pulse_e7", int'(O_pulse[0]), 0);
        repeat (100) step();
        check("hold_pulse_count", pcnt[0], 1);
        check("hold_level", int'(O_level[0]), 1);

        // clean release
        drive(3'b000);
        clear_pcnt();
        repeat (5) step();
        check("release_level_e5", int'(O_level[0]), 1);
        step();
        check("release_level_e6", int'(O_level[0]), 0);
        repeat (10) step();
        check("release_pulse_count", pcnt[0], 0);

        // bounce on channel 1, final toggle to 1 is held
        clear_pcnt();
        drive(3'b010); step();
        drive(3'b000); step();
        drive(3'b010); step();
        drive(3'b000); step();
        drive(3'b010);
        repeat (5) step();
        check("bounce_level_e5", int'(O_level[1]), 0);
        check("bounce_pulses_e5", pcnt[1], 0);
        step();
        check("bounce_pulse_e6", int'(O_pulse[1]), 1);
        check("bounce_level_e6", int'(O_level[1]), 1);
        repeat (10) step();
        check("bounce_pulse_count", pcnt[1], 1);
        drive(3'b000);
        repeat (10) step();

        // simultaneous presses
        drive(3'b101);
        clear_pcnt();
        repeat (6) step();
        check("simul_pulse_e6", int'(O_pulse), 3'b101);
        repeat (10) step();
        check("simul_cnt0", pcnt[0], 1);
        check("simul_cnt1", pcnt[1], 0);
        check("simul_cnt2", pcnt[2], 1);

        // reset mid-count, then fresh press after release
        drive(3'b111);
        repeat (4) step();
        I_reset_n = 1'b0;
        #1;
        check("midreset_level", int'(O_level), 0);
        check("midreset_pulse", int'(O_pulse), 0);
        repeat (2) @(negedge I_clk);
        I_reset_n = 1'b1;
        clear_pcnt();
        repeat (5) step();
        check("post_reset_level_e5", int'(O_level), 0);
        step();
        check("post_reset_pulse_e6", int'(O_pulse), 3'b111);
        // reset while the pulse is high
        I_reset_n = 1'b0;
        #1;
        check("pulse_reset_pulse", int'(O_pulse), 0);
        check("pulse_reset_level", int'(O_level), 0);
        @(negedge I_clk);
        I_reset_n = 1'b1;
        clear_pcnt();
        repeat (20) step();
        check("fresh_press_count", pcnt[2], 1);
        drive(3'b000);
        repeat (10) step();

        // randomized bouncing with occasional resets
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) I_button_raw = NB'($urandom_range(0, 7));
            else I_button_raw[$urandom_range(0, NB-1)] ^= 1'b1;
            hold = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 10);
            repeat (hold) @(negedge I_clk);
            if ($urandom_range(0, 24) == 0) begin
                #2;
                I_reset_n = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge I_clk);
                I_reset_n = 1'b1;
            end
        end
        repeat (20) @(negedge I_clk);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
Input-conditioning stage directly upstream of the ALU operand/opcode capture logic. It takes the raw, asynchronous, bouncing push-button lines from the board, synchronises them, and debounces each one independently. Per button it produces a clean debounced level and a single-cycle press pulse. The pulse drives the capture enables, so one physical press loads exactly one value.

Parameters:
N_BUTTONS, 3, number of independent button channels
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a level change is accepted (10 ms at 100 MHz); must be >= 1
NB_COUNTER, 20, width of each per-channel counter; must satisfy 2^NB_COUNTER > DEBOUNCE_CYCLES

Ports:
I_clk  input  1  system clock; all state updates on its rising edge
I_reset_n  input  1  asynchronous, active-low reset
I_button_raw  input  N_BUTTONS  raw push-button lines, asynchronous to I_clk, bouncing
O_level  output  N_BUTTONS  debounced button state, registered
O_pulse  output  N_BUTTONS  one-cycle high strobe on each accepted 0->1 transition of O_level, registered

Behaviour:
- Reset (I_reset_n=0, asynchronous, takes effect immediately without a clock edge):
  - synchroniser flops, counters, O_level and O_pulse all go to 0.
  - On release, the block resumes on the next rising edge of I_clk.
- Synchroniser: two flops per channel, sync1 <= raw and sync2 <= sync1. Only sync2 is used downstream. No other logic may read I_button_raw.
- Per-channel debounce, evaluated every edge. Channels are fully independent, with no shared counter and no priority between channels.
  - sync2 == O_level: counter <= 0. Any glitch shorter than the window restarts the count.
  - sync2 != O_level and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync2 != O_level and counter == DEBOUNCE_CYCLES-1: O_level <= sync2, counter <= 0.
  - The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Pulse:
  - O_pulse[i] <= 1 in exactly the cycle O_level[i] is updated 0->1; otherwise O_pulse[i] <= 0.
  - O_pulse and O_level rise on the same edge.
  - The pulse lasts exactly one cycle regardless of how long the button is held.
  - No pulse is generated on release (1->0).
- Latency: raw line held steady from before edge 1 -> O_level/O_pulse change after edge DEBOUNCE_CYCLES+2. That is 2 synchroniser cycles plus DEBOUNCE_CYCLES count cycles. Same latency for release.
- Boundary conditions:
  - Bounce that returns to the old level at any count value: counter clears, no output change.
  - Bounce after acceptance: a new transition requires a full DEBOUNCE_CYCLES window.
  - Simultaneous presses on several channels: each channel produces its own pulse, possibly in the same cycle.
  - Reset asserted mid-count or while O_pulse=1: everything clears at once; no pulse is emitted after reset for that press.
  - Button held through reset release: treated as a fresh press. Exactly one pulse occurs DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
  - DEBOUNCE_CYCLES=1: acceptance happens on the first edge where sync2 differs.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, NB_COUNTER=3, N_BUTTONS=3; edges are counted from the first rising edge after the raw change.

1. Reset check: I_reset_n=0 with I_button_raw=3'b111, no clock edges -> O_level=0 and O_pulse=0 immediately.
2. Clean press: raw[0] 0->1 and held -> O_level[0]=1 and O_pulse[0]=1 after edge 6; O_pulse[0]=0 after edge 7 and stays 0 for a 100-cycle hold.
3. Clean release: from the state of scenario 2, raw[0] 1->0 -> O_level[0]=0 after edge 6; O_pulse stays 0 throughout.
4. Bounce: raw[1] toggles 1,0,1,0 on consecutive cycles, then held 1 -> counter restarts on each toggle, O_level[1]=0 during the bounce, and exactly one O_pulse[1] occurs 6 edges after the final toggle.
5. Simultaneous presses: raw=3'b101 in one cycle -> O_pulse=3'b101 on the same cycle after edge 6, and O_pulse[1]=0.
6. Reset mid-operation: press raw[2], assert I_reset_n=0 after edge 4, release reset 2 cycles later with raw[2] still 1 -> outputs go to 0 immediately on reset assertion; exactly one O_pulse[2] occurs after post-reset edge 6.
